// File: rtl/blake2_host_tx.sv
// blake2_host_tx: drives one BLAKE2 job into the core I/O port: 10 CONF bytes, 64-byte key/message blocks, then collects digest bytes.
// Latency: CONF byte 0 one cycle after start_i; an accepted source byte appears on data_o one cycle later; digest bytes forwarded in one cycle.
// Backpressure: msg_v_i low stalls the block stream (index holds, valid_o low); ready_i gates every block, sampled only after HOLDOFF idle cycles.
module blake2_host_tx #(
    parameter int HOLDOFF = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        msg_v_i,
    input  logic [7:0]  msg_i,
    output logic        msg_rdy_o,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    input  logic        ready_i,
    input  logic        hash_v_i,
    input  logic [7:0]  hash_i,
    output logic        res_v_o,
    output logic [7:0]  res_o,
    output logic [5:0]  res_idx_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_WAIT_RDY,
        S_BLOCK,
        S_HASH
    } state_t;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    // Job parameters latched at start.
    state_t      state_q, state_d;
    logic [5:0]  kk_q, kk_d;
    logic [5:0]  nn_q, nn_d;
    logic [63:0] ll_q, ll_d;

    // Sequencing counters.
    logic [3:0]  conf_cnt_q, conf_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [63:0] mcnt_q, mcnt_d;
    logic [63:0] blk_cnt_q, blk_cnt_d;
    logic [5:0]  hcnt_q, hcnt_d;

    // Registered outputs.
    logic        valid_q, valid_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  data_q, data_d;
    logic        res_v_q, res_v_d;
    logic [7:0]  res_q, res_d;
    logic [5:0]  res_idx_q, res_idx_d;
    logic        done_q, done_d;

    // Block bookkeeping derived from the latched job parameters.
    logic        kk_nz;
    logic        key_blk;
    logic [63:0] data_blks;
    logic [63:0] n_blks;
    logic        last_blk;
    logic        from_src;
    logic        advance;
    logic [1:0]  blk_cmd;

    // Picks CONF byte n: key length, digest length, then the 64-bit message length LSB first.
    function automatic logic [7:0] conf_byte(input logic [3:0] n, input logic [5:0] kk,
                                             input logic [5:0] nn, input logic [63:0] ll);
        logic [63:0] sh;
        sh = ll >> {n - 4'd2, 3'b000};
        case (n)
            4'd0:    conf_byte = {2'b00, kk};
            4'd1:    conf_byte = {2'b00, nn};
            default: conf_byte = sh[7:0];
        endcase
    endfunction

    // Block count, block type and per-byte source selection.
    always_comb begin
        kk_nz     = (kk_q != 6'd0);
        key_blk   = kk_nz && (blk_cnt_q == 64'd0);
        // An empty message still needs one all-zero block unless a key block carries the job.
        if (ll_q == 64'd0) begin
            data_blks = kk_nz ? 64'd0 : 64'd1;
        end else begin
            data_blks = (ll_q >> 6) + {63'd0, |ll_q[5:0]};
        end
        n_blks    = data_blks + {63'd0, kk_nz};
        last_blk  = (blk_cnt_q == n_blks - 64'd1);
        from_src  = key_blk ? (idx_q < kk_q) : (mcnt_q < ll_q);
        advance   = !from_src || msg_v_i;
        // A first block keeps START even when it is also the final one, except its byte 63.
        if ((idx_q == 6'd63) && last_blk) begin
            blk_cmd = CMD_LAST;
        end else if (blk_cnt_q == 64'd0) begin
            blk_cmd = CMD_START;
        end else begin
            blk_cmd = CMD_DATA;
        end
    end

    // Source handshake is only offered for bytes that really come from the source; reset withdraws it at once.
    assign msg_rdy_o = (state_q == S_BLOCK) && from_src && !reset;

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_d    = state_q;
        kk_d       = kk_q;
        nn_d       = nn_q;
        ll_d       = ll_q;
        conf_cnt_d = conf_cnt_q;
        hold_cnt_d = hold_cnt_q;
        idx_d      = idx_q;
        mcnt_d     = mcnt_q;
        blk_cnt_d  = blk_cnt_q;
        hcnt_d     = hcnt_q;
        valid_d    = 1'b0;
        cmd_d      = cmd_q;
        data_d     = data_q;
        res_v_d    = 1'b0;
        res_d      = res_q;
        res_idx_d  = res_idx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    kk_d       = kk_i;
                    nn_d       = nn_i;
                    ll_d       = ll_i;
                    idx_d      = 6'd0;
                    mcnt_d     = 64'd0;
                    blk_cnt_d  = 64'd0;
                    hcnt_d     = 6'd0;
                    // CONF byte 0 goes out with the state change so CONF is exactly 10 valid cycles.
                    valid_d    = 1'b1;
                    cmd_d      = CMD_CONF;
                    data_d     = {2'b00, kk_i};
                    conf_cnt_d = 4'd1;
                    state_d    = S_CONF;
                end
            end

            S_CONF: begin
                if (conf_cnt_q == 4'd10) begin
                    hold_cnt_d = 16'd0;
                    state_d    = S_WAIT_RDY;
                end else begin
                    valid_d    = 1'b1;
                    cmd_d      = CMD_CONF;
                    data_d     = conf_byte(conf_cnt_q, kk_q, nn_q, ll_q);
                    conf_cnt_d = conf_cnt_q + 4'd1;
                end
            end

            S_WAIT_RDY: begin
                if (hold_cnt_q != 16'd0) begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end else if (ready_i) begin
                    state_d = S_BLOCK;
                end
            end

            S_BLOCK: begin
                if (advance) begin
                    valid_d = 1'b1;
                    cmd_d   = blk_cmd;
                    data_d  = from_src ? msg_i : 8'h00;
                    idx_d   = idx_q + 6'd1;
                    if (!key_blk) begin
                        mcnt_d = mcnt_q + 64'd1;
                    end
                    if (idx_q == 6'd63) begin
                        blk_cnt_d = blk_cnt_q + 64'd1;
                        if (last_blk) begin
                            hcnt_d  = 6'd0;
                            state_d = S_HASH;
                        end else begin
                            hold_cnt_d = 16'(HOLDOFF);
                            state_d    = S_WAIT_RDY;
                        end
                    end
                end
            end

            S_HASH: begin
                if (nn_q == 6'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (hash_v_i) begin
                    res_v_d   = 1'b1;
                    res_d     = hash_i;
                    res_idx_d = hcnt_q;
                    hcnt_d    = hcnt_q + 6'd1;
                    if (({1'b0, hcnt_q} + 7'd1) == {1'b0, nn_q}) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kk_q       <= 6'd0;
            nn_q       <= 6'd0;
            ll_q       <= 64'd0;
            conf_cnt_q <= 4'd0;
            hold_cnt_q <= 16'd0;
            idx_q      <= 6'd0;
            mcnt_q     <= 64'd0;
            blk_cnt_q  <= 64'd0;
            hcnt_q     <= 6'd0;
            valid_q    <= 1'b0;
            cmd_q      <= 2'd0;
            data_q     <= 8'd0;
            res_v_q    <= 1'b0;
            res_q      <= 8'd0;
            res_idx_q  <= 6'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kk_q       <= kk_d;
            nn_q       <= nn_d;
            ll_q       <= ll_d;
            conf_cnt_q <= conf_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            idx_q      <= idx_d;
            mcnt_q     <= mcnt_d;
            blk_cnt_q  <= blk_cnt_d;
            hcnt_q     <= hcnt_d;
            valid_q    <= valid_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            res_v_q    <= res_v_d;
            res_q      <= res_d;
            res_idx_q  <= res_idx_d;
            done_q     <= done_d;
        end
    end

    assign valid_o   = valid_q;
    assign cmd_o     = cmd_q;
    assign data_o    = data_q;
    assign res_v_o   = res_v_q;
    assign res_o     = res_q;
    assign res_idx_o = res_idx_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_blake2_host_tx.sv
// tb_blake2_host_tx: table of hash jobs with hand-computed CONF bytes, block counts and source accepts,
// plus a hand-written mid-job reset sequence.
// Source byte n is 0x61+n (key bytes first, then message); digest byte k is 0x11*(k+1).
module tb_blake2_host_tx;

    localparam int HOLDOFF = 4;
    localparam int BUDGET  = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [5:0]  kk_i;
    logic [5:0]  nn_i;
    logic [63:0] ll_i;
    logic        msg_v_i;
    logic [7:0]  msg_i;
    logic        msg_rdy_o;
    logic        valid_o;
    logic [1:0]  cmd_o;
    logic [7:0]  data_o;
    logic        ready_i;
    logic        hash_v_i;
    logic [7:0]  hash_i;
    logic        res_v_o;
    logic [7:0]  res_o;
    logic [5:0]  res_idx_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    blake2_host_tx #(.HOLDOFF(HOLDOFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .kk_i      (kk_i),
        .nn_i      (nn_i),
        .ll_i      (ll_i),
        .msg_v_i   (msg_v_i),
        .msg_i     (msg_i),
        .msg_rdy_o (msg_rdy_o),
        .valid_o   (valid_o),
        .cmd_o     (cmd_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .hash_v_i  (hash_v_i),
        .hash_i    (hash_i),
        .res_v_o   (res_v_o),
        .res_o     (res_o),
        .res_idx_o (res_idx_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    typedef struct {
        logic [5:0]  kk;
        logic [5:0]  nn;
        logic [63:0] ll;
        logic [79:0] conf;      // expected CONF bytes, byte 0 in bits [7:0]
        int          blocks;    // expected block count
        int          accepts;   // expected source handshakes
        int          stall_at;  // source index where msg_v_i drops (-1: never)
        int          stall_len;
        int          stall_blk; // block that absorbs the stall
        int          rdy_gap;   // cycles ready_i is held low after each non-final block
    } vec_t;

    vec_t vecs [6];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] src_byte(input int n);
        return 8'(n + 32'h61);
    endfunction

    function automatic logic [7:0] hash_byte(input int k);
        return 8'((k + 1) * 17);
    endfunction

    function automatic logic [7:0] exp_data(input vec_t v, input int b, input int i);
        int          kk;
        logic [63:0] m;
        kk = int'(v.kk);
        if (kk != 0 && b == 0) begin
            return (i < kk) ? src_byte(i) : 8'h00;
        end
        m = 64'((b - ((kk != 0) ? 1 : 0)) * 64 + i);
        return (m < v.ll) ? src_byte(kk + int'(m)) : 8'h00;
    endfunction

    function automatic logic [1:0] exp_cmd(input vec_t v, input int b, input int i);
        if (i == 63 && b == v.blocks - 1) return 2'd3;
        if (b == 0) return 2'd1;
        return 2'd2;
    endfunction

    task automatic run_job(input int id, input vec_t v);
        int nobs, ptr, acc, nres, ndone, cyc, stall_rem, gap_rem, hsent, post, total;
        int last_end, blk_start, k, b, i, exp_gap;
        bit fin;
        nobs = 0; ptr = 0; acc = 0; nres = 0; ndone = 0; cyc = 0; gap_rem = 0;
        hsent = 0; post = 0; last_end = 0; blk_start = 0; fin = 1'b0;
        total     = 10 + 64 * v.blocks;
        stall_rem = v.stall_len;

        @(negedge clk);
        chk($sformatf("j%0d busy before start", id), 64'(busy_o), 64'd0);
        start_i = 1'b1;
        kk_i    = v.kk;
        nn_i    = v.nn;
        ll_i    = v.ll;

        while (!fin && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start_i  = 1'b0;
            hash_v_i = 1'b0;

            if (valid_o) begin
                k = nobs;
                if (k < 10) begin
                    chk($sformatf("j%0d conf%0d cmd", id, k), 64'(cmd_o), 64'd0);
                    chk($sformatf("j%0d conf%0d data", id, k), 64'(data_o), 64'(v.conf[8*k +: 8]));
                    if (k == 9) last_end = cyc;
                end else if (k < total) begin
                    b = (k - 10) / 64;
                    i = (k - 10) % 64;
                    chk($sformatf("j%0d b%0d i%0d data", id, b, i), 64'(data_o), 64'(exp_data(v, b, i)));
                    chk($sformatf("j%0d b%0d i%0d cmd", id, b, i), 64'(cmd_o), 64'(exp_cmd(v, b, i)));
                    if (i == 0) begin
                        exp_gap = (b == 0) ? 3 : ((v.rdy_gap > 0) ? v.rdy_gap + 2 : HOLDOFF + 2);
                        chk($sformatf("j%0d b%0d start gap", id, b), 64'(cyc - last_end), 64'(exp_gap));
                        blk_start = cyc;
                    end
                    if (i == 63) begin
                        chk($sformatf("j%0d b%0d span", id, b), 64'(cyc - blk_start),
                            64'(63 + ((b == v.stall_blk) ? v.stall_len : 0)));
                        last_end = cyc;
                        if (v.rdy_gap > 0 && b < v.blocks - 1) gap_rem = v.rdy_gap;
                    end
                end
                nobs++;
            end

            if (res_v_o) begin
                chk($sformatf("j%0d res%0d data", id, nres), 64'(res_o), 64'(hash_byte(nres)));
                chk($sformatf("j%0d res%0d idx", id, nres), 64'(res_idx_o), 64'(nres));
                nres++;
            end

            if (done_o) begin
                ndone++;
                chk($sformatf("j%0d done after nn bytes", id), 64'(nres), 64'(v.nn));
                chk($sformatf("j%0d busy at done", id), 64'(busy_o), 64'd0);
                post = 2;
            end else if (post > 0) begin
                post--;
                if (post == 0) fin = 1'b1;
            end

            ready_i = (gap_rem == 0);
            if (gap_rem > 0) gap_rem--;

            if (ptr == v.stall_at && stall_rem > 0 && msg_rdy_o) begin
                msg_v_i = 1'b0;
                stall_rem--;
            end else begin
                msg_v_i = 1'b1;
                msg_i   = src_byte(ptr);
                if (msg_rdy_o) begin
                    ptr++;
                    acc++;
                end
            end

            if (nobs == total && hsent < int'(v.nn)) begin
                hash_v_i = 1'b1;
                hash_i   = hash_byte(hsent);
                hsent++;
            end else if (nobs > 0 && nobs < 10) begin
                // Stray start and digest strobes while configuring must be ignored.
                hash_v_i = 1'b1;
                hash_i   = 8'hEE;
                start_i  = 1'b1;
                kk_i     = 6'h2A;
                nn_i     = 6'h15;
                ll_i     = 64'hFFFF;
            end
        end

        msg_v_i  = 1'b0;
        hash_v_i = 1'b0;
        start_i  = 1'b0;
        ready_i  = 1'b1;
        chk($sformatf("j%0d finished in budget", id), 64'(fin), 64'd1);
        chk($sformatf("j%0d valid byte count", id), 64'(nobs), 64'(total));
        chk($sformatf("j%0d source accepts", id), 64'(acc), 64'(v.accepts));
        chk($sformatf("j%0d done pulses", id), 64'(ndone), 64'd1);
        chk($sformatf("j%0d result count", id), 64'(nres), 64'(v.nn));
    endtask

    task automatic reset_mid_job();
        logic [79:0] rconf;
        int nobs, acc, cyc;
        bit hit;
        rconf = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h00};
        nobs = 0; acc = 0; cyc = 0; hit = 1'b0;

        @(negedge clk);
        start_i = 1'b1;
        kk_i    = 6'd0;
        nn_i    = 6'd4;
        ll_i    = 64'h0807060504030201;
        ready_i = 1'b1;

        while (!hit && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (valid_o) begin
                if (nobs < 10) begin
                    chk($sformatf("rst conf%0d data", nobs), 64'(data_o), 64'(rconf[8*nobs +: 8]));
                end else begin
                    chk($sformatf("rst blk byte%0d", nobs - 10), 64'(data_o), 64'(src_byte(nobs - 10)));
                    chk($sformatf("rst blk cmd%0d", nobs - 10), 64'(cmd_o), 64'd1);
                end
                nobs++;
            end
            msg_v_i = 1'b1;
            msg_i   = src_byte(acc);
            if (nobs == 41) begin
                hit   = 1'b1;
                reset = 1'b1;
                #1;
                chk("rst msg_rdy during reset", 64'(msg_rdy_o), 64'd0);
            end else if (msg_rdy_o) begin
                acc++;
            end
        end
        chk("rst reached byte 30", 64'(hit), 64'd1);
        chk("rst accepts before reset", 64'(acc), 64'd31);

        @(negedge clk);
        chk("rst valid_o", 64'(valid_o), 64'd0);
        chk("rst cmd_o", 64'(cmd_o), 64'd0);
        chk("rst data_o", 64'(data_o), 64'd0);
        chk("rst msg_rdy_o", 64'(msg_rdy_o), 64'd0);
        chk("rst res_v_o", 64'(res_v_o), 64'd0);
        chk("rst res_o", 64'(res_o), 64'd0);
        chk("rst res_idx_o", 64'(res_idx_o), 64'd0);
        chk("rst busy_o", 64'(busy_o), 64'd0);
        chk("rst done_o", 64'(done_o), 64'd0);
        reset = 1'b0;

        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk($sformatf("post rst msg_rdy c%0d", n), 64'(msg_rdy_o), 64'd0);
            chk($sformatf("post rst valid c%0d", n), 64'(valid_o), 64'd0);
        end
        msg_v_i = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start_i  = 1'b0;
        kk_i     = 6'd0;
        nn_i     = 6'd0;
        ll_i     = 64'd0;
        msg_v_i  = 1'b0;
        msg_i    = 8'd0;
        ready_i  = 1'b1;
        hash_v_i = 1'b0;
        hash_i   = 8'd0;

        vecs[0] = '{kk: 6'd0,  nn: 6'd32, ll: 64'd3,   conf: {56'h0, 8'h03, 8'h20, 8'h00},
                    blocks: 1, accepts: 3,   stall_at: -1, stall_len: 0, stall_blk: -1, rdy_gap: 0};
        vecs[1] = '{kk: 6'd0,  nn: 6'd4,  ll: 64'd0,   conf: {64'h0, 8'h04, 8'h00},
                    blocks: 1, accepts: 0,   stall_at: -1, stall_len: 0, stall_blk: -1, rdy_gap: 0};
        vecs[2] = '{kk: 6'd32, nn: 6'd4,  ll: 64'd64,  conf: {56'h0, 8'h40, 8'h04, 8'h20},
                    blocks: 2, accepts: 96,  stall_at: -1, stall_len: 0, stall_blk: -1, rdy_gap: 0};
        vecs[3] = '{kk: 6'd0,  nn: 6'd4,  ll: 64'd100, conf: {56'h0, 8'h64, 8'h04, 8'h00},
                    blocks: 2, accepts: 100, stall_at: 10, stall_len: 5, stall_blk: 0, rdy_gap: 20};
        vecs[4] = '{kk: 6'd5,  nn: 6'd1,  ll: 64'd0,   conf: {64'h0, 8'h01, 8'h05},
                    blocks: 1, accepts: 5,   stall_at: -1, stall_len: 0, stall_blk: -1, rdy_gap: 0};
        vecs[5] = '{kk: 6'd63, nn: 6'd0,  ll: 64'd130, conf: {56'h0, 8'h82, 8'h00, 8'h3F},
                    blocks: 4, accepts: 193, stall_at: -1, stall_len: 0, stall_blk: -1, rdy_gap: 0};

        repeat (3) @(negedge clk);
        chk("reset valid_o", 64'(valid_o), 64'd0);
        chk("reset cmd_o", 64'(cmd_o), 64'd0);
        chk("reset data_o", 64'(data_o), 64'd0);
        chk("reset msg_rdy_o", 64'(msg_rdy_o), 64'd0);
        chk("reset res_v_o", 64'(res_v_o), 64'd0);
        chk("reset res_o", 64'(res_o), 64'd0);
        chk("reset res_idx_o", 64'(res_idx_o), 64'd0);
        chk("reset busy_o", 64'(busy_o), 64'd0);
        chk("reset done_o", 64'(done_o), 64'd0);
        reset = 1'b0;

        for (int j = 0; j < 6; j++) begin
            run_job(j, vecs[j]);
        end

        reset_mid_job();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
